// File: rtl/axistream_snooper.sv
// Passive AXI-Stream tap: copies each observed packet into packet memory through
// the snooper write port, claiming a buffer on the first beat or dropping the packet.
module axistream_snooper #(
    parameter int PACKMEM_ADDR_WIDTH = 8,
    parameter int PACKMEM_DATA_WIDTH = 64,
    parameter int INC_WIDTH          = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PACKMEM_DATA_WIDTH-1:0]     snoop_TDATA,
    input  logic [PACKMEM_DATA_WIDTH/8-1:0]   snoop_TKEEP,
    input  logic                              snoop_TVALID,
    input  logic                              snoop_TREADY,
    input  logic                              snoop_TLAST,
    output logic [PACKMEM_ADDR_WIDTH-1:0]     sn_addr,
    output logic [PACKMEM_DATA_WIDTH-1:0]     sn_wr_data,
    output logic                              sn_wr_en,
    output logic [INC_WIDTH-1:0]              sn_byte_inc,
    output logic                              sn_done,
    output logic                              rdy_for_sn_ack,
    input  logic                              rdy_for_sn
);
    localparam int KEEP_W = PACKMEM_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, CAPTURE, DROP} state_t;

    state_t                          state_q, state_d;
    logic [PACKMEM_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                            ovf_q, ovf_d;
    logic [PACKMEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [PACKMEM_DATA_WIDTH-1:0]   data_q, data_d;
    logic                            wen_q, wen_d;
    logic [INC_WIDTH-1:0]            inc_q, inc_d;
    logic                            done_q, done_d;
    logic                            ack_q, ack_d;
    logic                            beat;

    function automatic logic [INC_WIDTH-1:0] popcount(input logic [KEEP_W-1:0] keep);
        logic [INC_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + INC_WIDTH'(keep[i]);
        end
        return n;
    endfunction

    assign beat = snoop_TVALID & snoop_TREADY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wen_d   = 1'b0;
        inc_d   = '0;
        done_d  = 1'b0;
        ack_d   = 1'b0;
        if (beat) begin
            unique case (state_q)
                IDLE: begin
                    // The buffer-ready decision is taken on the first beat only.
                    if (rdy_for_sn) begin
                        ack_d  = 1'b1;
                        wen_d  = 1'b1;
                        addr_d = '0;
                        data_d = snoop_TDATA;
                        inc_d  = popcount(snoop_TKEEP);
                        done_d = snoop_TLAST;
                        if (snoop_TLAST) begin
                            cnt_d = '0;
                        end else begin
                            cnt_d   = PACKMEM_ADDR_WIDTH'(1);
                            state_d = CAPTURE;
                        end
                    end else if (!snoop_TLAST) begin
                        state_d = DROP;
                    end
                end
                CAPTURE: begin
                    if (!ovf_q) begin
                        wen_d  = 1'b1;
                        addr_d = cnt_q;
                        data_d = snoop_TDATA;
                        inc_d  = popcount(snoop_TKEEP);
                        cnt_d  = cnt_q + PACKMEM_ADDR_WIDTH'(1);
                        if (&cnt_q) ovf_d = 1'b1;
                    end
                    if (snoop_TLAST) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                DROP: begin
                    if (snoop_TLAST) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            inc_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            inc_q   <= inc_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    assign sn_addr        = addr_q;
    assign sn_wr_data     = data_q;
    assign sn_wr_en       = wen_q;
    assign sn_byte_inc    = inc_q;
    assign sn_done        = done_q;
    assign rdy_for_sn_ack = ack_q;
endmodule
